// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_W data bits (LSB first) followed by one parity bit,
// with per-frame parity error flag and a saturating error counter.
module serial_parity_checker #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              odd_mode,
  input  logic              clr_cnt,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              pec,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    idx_q;
  logic                acc_q;
  logic                odd_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                frame_start;
  logic                data_accept;
  logic                par_accept;
  logic                frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    data_accept = 1'b0;
    par_accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (bit_valid) begin
          data_accept = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_valid) begin
          par_accept = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error uses the mode latched at frame start, so mid-frame odd_mode changes are ignored.
  assign frame_err = acc_q ^ bit_in ^ odd_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      acc_q    <= 1'b0;
      odd_q    <= 1'b0;
      shreg_q  <= '0;
      data_out <= '0;
      pec      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= par_accept;
      if (frame_start) begin
        idx_q <= '0;
        acc_q <= 1'b0;
        odd_q <= odd_mode;
      end
      if (data_accept) begin
        shreg_q[idx_q] <= bit_in;
        acc_q          <= acc_q ^ bit_in;
        idx_q          <= idx_q + 1'b1;
      end
      if (par_accept) begin
        data_out <= shreg_q;
        pec      <= frame_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (par_accept && frame_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: default instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation checks.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       bit_in;
  logic       bit_valid;
  logic       odd_mode;
  logic       clr_cnt;
  logic       busy;
  logic [3:0] data_out;
  logic       done;
  logic       pec;
  logic [7:0] err_cnt;
  logic       busy2;
  logic [3:0] data_out2;
  logic       done2;
  logic       pec2;
  logic [1:0] err_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .odd_mode(odd_mode), .clr_cnt(clr_cnt), .busy(busy), .data_out(data_out),
    .done(done), .pec(pec), .err_cnt(err_cnt)
  );

  serial_parity_checker #(.DATA_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .odd_mode(odd_mode), .clr_cnt(clr_cnt), .busy(busy2), .data_out(data_out2),
    .done(done2), .pec(pec2), .err_cnt(err_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [3:0] d, input logic p, input logic odd, input int gap,
                           input int toggle_at, input logic clr, input logic exp_pec,
                           input int exp_cnt, input int exp_cnt2);
    odd_mode = odd;
    start    = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_at_start", busy, 1);
    check("done_at_start", done, 0);
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < gap; g++) begin
        cyc();
        check("busy_in_gap", busy, 1);
        check("done_in_gap", done, 0);
      end
      bit_in    = (i < 4) ? d[i] : p;
      bit_valid = 1'b1;
      clr_cnt   = (i == 4) ? clr : 1'b0;
      cyc();
      bit_valid = 1'b0;
      clr_cnt   = 1'b0;
      if (i == toggle_at) odd_mode = ~odd_mode;
      if (i < 4) begin
        check("busy_mid", busy, 1);
        check("done_mid", done, 0);
      end
    end
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("data_out", data_out, d);
    check("pec", pec, exp_pec);
    check("err_cnt", err_cnt, exp_cnt);
    check("pec_w2", pec2, exp_pec);
    check("err_cnt_w2", err_cnt2, exp_cnt2);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    odd_mode = 1'b0; clr_cnt = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pec", pec, 0);
    check("rst_data", data_out, 0);
    check("rst_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // bits 1,0,1,1 LSB first -> 1101; three ones
    run_frame(4'b1101, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 0, 0);
    cyc();
    check("done_one_cycle", done, 0);
    run_frame(4'b1101, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 1, 1);
    // back-to-back: start issued in the done cycle
    run_frame(4'b1101, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 2, 2);
    run_frame(4'b0000, 1'b0, 1'b1, 0, -1, 1'b0, 1'b1, 3, 3);
    run_frame(4'b0000, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0, 3, 3);
    run_frame(4'b0000, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 3, 3);
    run_frame(4'b0000, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 3, 3);
    run_frame(4'b1101, 1'b1, 1'b0, 3, -1, 1'b0, 1'b0, 3, 3);
    cyc();

    // partial frame leaves outputs alone, then async reset aborts it
    odd_mode = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b1; cyc();
    bit_in = 1'b1; cyc();
    bit_valid = 1'b0;
    check("hold_data", data_out, 4'b1101);
    check("hold_pec", pec, 0);
    check("hold_cnt", err_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", data_out, 0);
    check("abort_pec", pec, 0);
    check("abort_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("no_done_after_abort", done, 0);
    end
    run_frame(4'b0110, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 0, 0);
    cyc();

    // saturation of the 2-bit counter
    run_frame(4'b1101, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 1, 1);
    run_frame(4'b1101, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 2, 2);
    run_frame(4'b1101, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 3, 3);
    run_frame(4'b1101, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 4, 3);
    run_frame(4'b1101, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 5, 3);
    // clear wins over a simultaneous error increment
    run_frame(4'b1101, 1'b0, 1'b0, 0, -1, 1'b1, 1'b1, 0, 0);
    cyc();
    check("done_low_end", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
